// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, oversample constant and baud divisor helper
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DIV_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Rounded clocks per oversample tick; the transmitter uses the same rounding.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - serial line, rate select and received-byte observables
interface uart_receiver_if;

    logic [1:0] baud_sel;
    logic       rx_serial;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_bussy;
    logic       rx_error;

    modport master (
        output baud_sel,
        output rx_serial,
        input  rx_byte,
        input  rx_valid,
        input  rx_bussy,
        input  rx_error
    );

    modport slave (
        input  baud_sel,
        input  rx_serial,
        output rx_byte,
        output rx_valid,
        output rx_bussy,
        output rx_error
    );

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator with synchronous clear
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == div - DIV_W'(1));

    // tick is registered, so it trails the terminal count by one clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            cnt  <= wrap ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive engine with 16x oversampling
module uart_receiver #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int OVERSAMPLE  = 16,
    parameter int BAUD0       = 9600,
    parameter int BAUD1       = 19200,
    parameter int BAUD2       = 57600,
    parameter int BAUD3       = 115200
) (
    input  logic            clk,
    input  logic            rst,
    uart_receiver_if.slave  bus
);
    import uart_pkg::*;

    if (OVERSAMPLE != 16) begin : g_oversample_check
        $error("uart_receiver supports only 16x oversampling");
    end

    localparam logic [DIV_W-1:0] DIV0 = DIV_W'(baud_div(CLK_FREQ_HZ, BAUD0));
    localparam logic [DIV_W-1:0] DIV1 = DIV_W'(baud_div(CLK_FREQ_HZ, BAUD1));
    localparam logic [DIV_W-1:0] DIV2 = DIV_W'(baud_div(CLK_FREQ_HZ, BAUD2));
    localparam logic [DIV_W-1:0] DIV3 = DIV_W'(baud_div(CLK_FREQ_HZ, BAUD3));

    rx_state_t        state;
    rx_state_t        state_nx;
    logic             rx_meta;
    logic             rx_s;
    logic [1:0]       baud_q;
    logic [DIV_W-1:0] div_sel;
    logic             tick;
    logic [3:0]       os_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;

    logic             mid_tick;
    logic             end_tick;
    logic             start_det;
    logic             os_clr;
    logic             shift_en;
    logic             valid_d;
    logic             error_d;

    // Two-flop synchronizer, reset to the idle-high line level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx_serial;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        case (baud_q)
            2'd0:    div_sel = DIV0;
            2'd1:    div_sel = DIV1;
            2'd2:    div_sel = DIV2;
            default: div_sel = DIV3;
        endcase
    end

    // Held in clear while idle so the first tick lands DIV clks after the start edge
    uart_baud_tick u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .div  (div_sel),
        .tick (tick)
    );

    assign mid_tick = tick && (os_cnt == 4'd7);
    assign end_tick = tick && (os_cnt == 4'd15);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!rx_s) state_nx = START;
            START:   if (mid_tick) state_nx = rx_s ? IDLE : DATA;
            DATA:    if (end_tick && (bit_cnt == 3'd7)) state_nx = STOP;
            STOP:    if (end_tick) state_nx = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        start_det = 1'b0;
        os_clr    = 1'b0;
        shift_en  = 1'b0;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        case (state)
            IDLE: begin
                start_det = !rx_s;
                os_clr    = !rx_s;
            end
            START:   os_clr   = mid_tick;
            DATA:    shift_en = end_tick;
            STOP: begin
                valid_d = end_tick && rx_s;
                error_d = end_tick && !rx_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_q       <= 2'd0;
            os_cnt       <= 4'd0;
            bit_cnt      <= 3'd0;
            shift        <= 8'h00;
            bus.rx_byte  <= 8'h00;
            bus.rx_valid <= 1'b0;
            bus.rx_error <= 1'b0;
            bus.rx_bussy <= 1'b0;
        end else begin
            if (start_det) begin
                baud_q  <= bus.baud_sel;
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (os_clr) begin
                os_cnt <= 4'd0;
            end else if (tick) begin
                os_cnt <= os_cnt + 4'd1;
            end
            // LSB arrives first, so each bit enters at the top and moves down
            if (shift_en) begin
                shift <= {rx_s, shift[7:1]};
            end
            if (valid_d) begin
                bus.rx_byte <= shift;
            end
            bus.rx_valid <= valid_d;
            bus.rx_error <= error_d;
            bus.rx_bussy <= (state != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;
    import uart_pkg::*;

    // 10 MHz keeps the slow-rate frames short: DIV = 65 / 33 / 11 / 5
    localparam int CLK_HZ = 10_000_000;
    localparam int DIV3   = 5;
    localparam int DIV0   = 65;
    localparam int BIT3   = DIV3 * 16;
    localparam int BIT0   = DIV0 * 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_receiver_if u_if ();

    uart_receiver #(.CLK_FREQ_HZ(CLK_HZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_valid = 0;
    int         n_err   = 0;
    int         n_both  = 0;
    logic [7:0] vbyte [0:15];
    int         vcyc  [0:15];

    always @(negedge clk) begin
        if (rst) begin
            if (u_if.rx_valid && n_valid < 16) begin
                vbyte[n_valid] = u_if.rx_byte;
                vcyc[n_valid]  = cyc;
            end
            if (u_if.rx_valid) n_valid++;
            if (u_if.rx_error) n_err++;
            if (u_if.rx_valid && u_if.rx_error) n_both++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    int   t_start;
    logic busy_all;

    task automatic send_frame(input logic [7:0] data, input int bit_clks, input logic stop_v,
                              input int n_data, input int sw_bit, input logic [1:0] sw_val);
        t_start  = cyc;
        busy_all = 1'b1;
        u_if.rx_serial = 1'b0;
        hold(bit_clks);
        busy_all &= u_if.rx_bussy;
        for (int i = 0; i < n_data; i++) begin
            if (i == sw_bit) u_if.baud_sel = sw_val;
            u_if.rx_serial = data[i];
            hold(bit_clks);
            busy_all &= u_if.rx_bussy;
        end
        if (n_data == 8) begin
            u_if.rx_serial = stop_v;
            hold(bit_clks);
        end
    endtask

    int   bv;
    int   be;
    int   lat;
    logic busy_seen;

    initial begin
        u_if.rx_serial = 1'b1;
        u_if.baud_sel  = 2'd3;
        hold(5);
        check("rst_byte",  32'(u_if.rx_byte),  'h00);
        check("rst_valid", 32'(u_if.rx_valid), 0);
        check("rst_busy",  32'(u_if.rx_bussy), 0);
        check("rst_error", 32'(u_if.rx_error), 0);
        rst = 1'b1;
        hold(20);

        check("div_50m_9600",   baud_div(50_000_000, 9600),   326);
        check("div_50m_19200",  baud_div(50_000_000, 19200),  163);
        check("div_50m_57600",  baud_div(50_000_000, 57600),  54);
        check("div_50m_115200", baud_div(50_000_000, 115200), 27);
        check("div_10m_9600",   baud_div(CLK_HZ, 9600),   65);
        check("div_10m_19200",  baud_div(CLK_HZ, 19200),  33);
        check("div_10m_57600",  baud_div(CLK_HZ, 57600),  11);
        check("div_10m_115200", baud_div(CLK_HZ, 115200), 5);

        // basic frame at the fastest rate
        bv = n_valid; be = n_err;
        send_frame(8'hA5, BIT3, 1'b1, 8, -1, 2'd0);
        hold(40);
        check("t1_valid_cnt", n_valid - bv, 1);
        check("t1_byte", 32'(u_if.rx_byte), 'hA5);
        check("t1_err_cnt", n_err - be, 0);
        check("t1_busy_in_frame", 32'(busy_all), 1);
        check("t1_busy_after", 32'(u_if.rx_bussy), 0);
        lat = vcyc[bv] - t_start;
        $display("t1 latency %0d clks", lat);
        check("t1_latency_in_range", 32'(lat >= 152 * DIV3 + 3 && lat <= 152 * DIV3 + 4), 1);

        // framing error, line held low two more bits
        bv = n_valid; be = n_err;
        send_frame(8'h3C, BIT3, 1'b0, 8, -1, 2'd0);
        hold(2 * BIT3);
        u_if.rx_serial = 1'b1;
        hold(3);
        check("t2_busy_3clk", 32'(u_if.rx_bussy), 1);
        hold(1);
        check("t2_busy_4clk", 32'(u_if.rx_bussy), 0);
        check("t2_err_cnt", n_err - be, 1);
        check("t2_valid_cnt", n_valid - bv, 0);
        check("t2_byte_kept", 32'(u_if.rx_byte), 'hA5);

        // glitch shorter than half a start bit
        bv = n_valid; be = n_err;
        busy_seen = 1'b0;
        u_if.rx_serial = 1'b0;
        repeat (20) begin
            @(negedge clk);
            busy_seen |= u_if.rx_bussy;
        end
        u_if.rx_serial = 1'b1;
        repeat (100) begin
            @(negedge clk);
            busy_seen |= u_if.rx_bussy;
        end
        check("t3_busy_seen", 32'(busy_seen), 1);
        check("t3_busy_after", 32'(u_if.rx_bussy), 0);
        check("t3_valid_cnt", n_valid - bv, 0);
        check("t3_err_cnt", n_err - be, 0);

        // back-to-back at the slowest rate
        u_if.baud_sel = 2'd0;
        hold(5);
        bv = n_valid; be = n_err;
        send_frame(8'h00, BIT0, 1'b1, 8, -1, 2'd0);
        send_frame(8'hFF, BIT0, 1'b1, 8, -1, 2'd0);
        hold(100);
        check("t4_valid_cnt", n_valid - bv, 2);
        check("t4_byte0", 32'(vbyte[bv]), 'h00);
        check("t4_byte1", 32'(vbyte[bv + 1]), 'hFF);
        check("t4_spacing", vcyc[bv + 1] - vcyc[bv], 10 * BIT0);
        check("t4_err_cnt", n_err - be, 0);

        // reset during data bit 4 of 0x5A
        u_if.baud_sel = 2'd3;
        hold(5);
        send_frame(8'h5A, BIT3, 1'b1, 4, -1, 2'd0);
        u_if.rx_serial = 1'b1;
        hold(40);
        rst = 1'b0;
        #1;
        check("t5_rst_busy",  32'(u_if.rx_bussy), 0);
        check("t5_rst_byte",  32'(u_if.rx_byte),  'h00);
        check("t5_rst_valid", 32'(u_if.rx_valid), 0);
        check("t5_rst_error", 32'(u_if.rx_error), 0);
        hold(4);
        rst = 1'b1;
        hold(20);
        bv = n_valid; be = n_err;
        send_frame(8'hC3, BIT3, 1'b1, 8, -1, 2'd0);
        hold(40);
        check("t5_valid_cnt", n_valid - bv, 1);
        check("t5_byte", 32'(u_if.rx_byte), 'hC3);
        check("t5_err_cnt", n_err - be, 0);

        // baud_sel moved mid-frame only affects the next frame
        bv = n_valid; be = n_err;
        send_frame(8'h81, BIT3, 1'b1, 8, 4, 2'd0);
        hold(40);
        check("t6_valid_cnt", n_valid - bv, 1);
        check("t6_byte", 32'(u_if.rx_byte), 'h81);
        bv = n_valid;
        send_frame(8'h6E, BIT0, 1'b1, 8, -1, 2'd0);
        hold(100);
        check("t6_next_valid_cnt", n_valid - bv, 1);
        check("t6_next_byte", 32'(u_if.rx_byte), 'h6E);
        lat = vcyc[bv] - t_start;
        check("t6_next_latency_in_range", 32'(lat >= 152 * DIV0 + 3 && lat <= 152 * DIV0 + 4), 1);
        check("t6_err_cnt", n_err - be, 0);

        check("valid_error_overlap", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receive engine. It uses 8N1 framing, sends the LSB first, and samples the line at 16x oversampling from the system clock. It produces the rx_byte / rx_valid / rx_bussy / rx_error observables that the UART bench clocking block samples. It pairs with the transmitter on the same baud_sel encoding, so a TX serial output can be looped straight into rx_serial.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency in Hz.
OVERSAMPLE, 16, ticks per bit. Fixed at 16; any other value is a compile-time error.
BAUD0 / BAUD1 / BAUD2 / BAUD3, 9600 / 19200 / 57600 / 115200, rates selected by baud_sel = 0 / 1 / 2 / 3.

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is sampled on clk.
baud_sel  input  2  baud rate select. Latched only on start-bit detection.
rx_serial  input  1  asynchronous serial line, idle high.
rx_byte  output  8  last correctly framed byte.
rx_valid  output  1  one-clk pulse: rx_byte was updated this cycle.
rx_bussy  output  1  high while a frame is in progress, including error recovery.
rx_error  output  1  one-clk pulse: framing error (stop bit sampled 0).

Behaviour:
- Reset (rst=0): all outputs are 0 and rx_byte=8'h00. FSM goes to IDLE, counters are cleared, synchronizer flops are set to 1. Reset mid-frame abandons the frame with no valid/error pulse.
- Synchronizer: rx_serial passes through 2 flops; the FSM sees only rx_s.
- Divisor: DIV[b] = round(CLK_FREQ_HZ / (BAUDb*16)). At 50 MHz this gives 326 / 163 / 54 / 27.
- Tick counter: counts 0..DIV-1. tick=1 for one clk when it reaches DIV-1.
- Start detection: in IDLE, when rx_s=0, the block latches baud_sel, clears the tick counter and os_cnt (4 bit), and moves to START.
- FSM states: IDLE, START, DATA, STOP, BREAK. os_cnt increments on each tick.
  - START: on the tick where os_cnt==7 (mid start bit):
    - rx_s=1 is a glitch: go to IDLE, no pulse.
    - otherwise clear os_cnt and go to DATA.
  - DATA: on the tick where os_cnt==15, shift rx_s into the shift register MSB (right shift, so LSB arrives first) and bit_cnt++. After the 8th bit go to STOP.
  - STOP: on the tick where os_cnt==15:
    - rx_s=1: rx_byte<=shift, rx_valid=1 for 1 clk, go to IDLE.
    - rx_s=0: rx_error=1 for 1 clk, rx_byte unchanged, go to BREAK.
  - BREAK: stay until rx_s=1, then go to IDLE. A new start can only be detected after the line has been seen high.
- rx_bussy: 1 in START, DATA, STOP and BREAK. It is registered, so it falls the cycle after the state returns to IDLE.
- Latency: rx_valid is registered and asserts on the clk after the mid-stop tick. That is 152*DIV + 3 to 152*DIV + 4 clks after the line falling edge; at DIV=27 this is 4107..4108.
- Back-to-back frames: a start bit immediately after the stop mid-sample is accepted. IDLE is re-entered 8 ticks before the end of the stop bit.
- baud_sel changes outside IDLE are ignored until the next start.
- rx_valid and rx_error never assert in the same cycle.

Decomposition:
- Shared package uart_pkg holds:
  - the rx_state_t enum {IDLE, START, DATA, STOP, BREAK};
  - the OVERSAMPLE constant;
  - the function baud_div(clk_hz, baud) returning the rounded divisor, shared with the transmitter.
- One sub-module, uart_baud_tick. It takes clk, rst, a sync clear, and a divisor, and outputs tick. The transmitter reuses it with its own divisor.

Test Plan:
1. Basic frame: baud_sel=3, frame 0xA5 sent at 432 clk/bit. Expect rx_byte=0xA5, one rx_valid pulse 4107..4108 clks after the falling edge, rx_error=0, and rx_bussy high for the duration.
2. Framing error: 0x3C sent with stop=0, line held low for 2 extra bits, then released. Expect one rx_error pulse, no rx_valid, rx_byte unchanged, and rx_bussy high until 3 clks after the line goes high.
3. Glitch: line low for 100 clks at baud_sel=3 (less than 7 ticks). Expect rx_bussy to pulse and return to 0, with no rx_valid and no rx_error.
4. Back-to-back at slowest rate: baud_sel=0, 0x00 then 0xFF with no idle gap. Expect two rx_valid pulses 5216*10 clks apart, giving 0x00 then 0xFF.
5. Reset mid-frame: assert rst during DATA bit 4 of 0x5A. Expect immediate outputs of 0, then a following 0xC3 frame received correctly.
6. baud_sel change mid-frame: switch baud_sel from 3 to 0 mid-byte of 0x81 sent at 115200. Expect 0x81 received correctly; the next frame is sampled at 9600.
